// File: rtl/shader_instr_fetch.sv
// Instruction fetch front-end: reads 128-bit program lines into a small FIFO and
// issues them one 32-bit instruction at a time to the shader core.
module shader_instr_fetch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          prog_base,
    input  logic [LEN_WIDTH-1:0] prog_len,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [127:0]         imem_rdata,
    output logic [31:0]          instruction,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          issued_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [31:0]          base_q;
    logic [LEN_WIDTH-1:0] lines_total_q, lines_req_q, remaining_q;
    logic [CW-1:0]        outstanding_q, fifo_cnt_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [1:0]           word_ptr_q;
    logic [31:0]          issued_q;
    logic [127:0]         fifo_mem_q [FIFO_DEPTH];

    logic                 run, start_ok, grant, push, accept, last, pop;
    logic [CW:0]          inflight;
    logic [LEN_WIDTH:0]   len_plus;
    logic [LEN_WIDTH-1:0] lines_total_d;
    logic [127:0]         head_line;

    logic unused_base;
    assign unused_base = ^prog_base[3:0];

    assign run           = (state_q == StRun);
    assign start_ok      = (state_q == StIdle) && start;
    assign len_plus      = {1'b0, prog_len} + (LEN_WIDTH + 1)'(3);
    assign lines_total_d = LEN_WIDTH'(len_plus >> 2);

    // Credit check: every granted line must already have a FIFO slot reserved.
    assign inflight  = {1'b0, fifo_cnt_q} + {1'b0, outstanding_q};
    assign imem_req  = run && (lines_req_q < lines_total_q) && (inflight < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = base_q + 32'({lines_req_q, 4'b0000});
    assign grant     = imem_req && imem_gnt;
    assign push      = run && imem_rvalid;

    assign head_line   = fifo_mem_q[rd_ptr_q];
    assign instr_valid = run && (fifo_cnt_q != '0);
    assign instruction = instr_valid ? head_line[{word_ptr_q, 5'b00000} +: 32] : 32'h0;
    assign accept      = instr_valid && instr_ready;
    assign last        = (remaining_q == LEN_WIDTH'(1));
    assign pop         = accept && ((word_ptr_q == 2'd3) || last);

    assign busy         = run;
    assign done         = (state_q == StDone);
    assign issued_count = issued_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (prog_len != '0) ? StRun : StDone;
            StRun:   if (accept && last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            base_q        <= '0;
            lines_total_q <= '0;
            lines_req_q   <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            word_ptr_q    <= '0;
            issued_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) issued_q <= issued_q + 32'd1;
            if (start_ok) begin
                base_q        <= {prog_base[31:4], 4'b0000};
                lines_total_q <= lines_total_d;
                remaining_q   <= prog_len;
                lines_req_q   <= '0;
                outstanding_q <= '0;
                fifo_cnt_q    <= '0;
                wr_ptr_q      <= '0;
                rd_ptr_q      <= '0;
                word_ptr_q    <= '0;
            end else if (run) begin
                if (grant) lines_req_q <= lines_req_q + LEN_WIDTH'(1);
                if (grant && !push) outstanding_q <= outstanding_q + CW'(1);
                else if (!grant && push) outstanding_q <= outstanding_q - CW'(1);
                if (push && !pop) fifo_cnt_q <= fifo_cnt_q + CW'(1);
                else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CW'(1);
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
                if (pop) word_ptr_q <= 2'd0;
                else if (accept) word_ptr_q <= word_ptr_q + 2'd1;
                if (accept) remaining_q <= remaining_q - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem_q[i] <= '0;
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_shader_instr_fetch.sv
// Directed bench for shader_instr_fetch: table of programs plus hand sequences for
// ready stall, second start while busy, zero length and mid-program reset.
module tb_shader_instr_fetch;

    localparam logic [31:0] MAGIC = 32'h5A00_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  prog_base;
    logic [15:0]  prog_len;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_gnt;
    logic         imem_rvalid;
    logic [127:0] imem_rdata;
    logic [31:0]  instruction;
    logic         instr_valid;
    logic         instr_ready;
    logic         busy;
    logic         done;
    logic [31:0]  issued_count;

    shader_instr_fetch #(.FIFO_DEPTH(4), .LEN_WIDTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prog_base    (prog_base),
        .prog_len     (prog_len),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] base;
        logic [15:0] len;
        bit          rnd_gnt;
        bit          rnd_ready;
        int          exp_lines;
    } vec_t;

    resp_t       rq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          grant_cnt, exp_idx;
    logic [31:0] exp_base;
    int          exp_len;
    logic [31:0] issued_total = 0;
    bit          gnt_rand = 0, ready_rand = 0, ready_hold = 0;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = 0;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = a + 32'(4 * k) + MAGIC;
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        instr_ready = ready_hold ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = line_of(rq[0].addr);
            void'(rq.pop_front());
        end
        @(negedge clk);
        if (prev_pend) begin
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, prev_addr);
        end
        prev_pend = imem_req && !imem_gnt;
        prev_addr = imem_addr;
        if (imem_req && imem_gnt) begin
            chk("req_addr", imem_addr, exp_base + 32'(grant_cnt) * 32'd16);
            rq.push_back('{imem_addr, cyc + 2});
            grant_cnt++;
        end
        if (instr_valid && instr_ready) begin
            chk("accept_in_range", {31'b0, exp_idx < exp_len}, 32'd1);
            chk("instr", instruction, exp_base + 32'(exp_idx) * 32'd4 + MAGIC);
            exp_idx++;
            issued_total++;
        end
    endtask

    task automatic launch(input logic [31:0] base, input logic [15:0] len);
        prog_base = base;
        prog_len  = len;
        start     = 1'b1;
        exp_base  = {base[31:4], 4'b0000};
        exp_len   = int'(len);
        exp_idx   = 0;
        grant_cnt = 0;
        step();
        start = 1'b0;
        chk("busy_t1", {31'b0, busy}, {31'b0, len != 0});
        chk("req_t1", {31'b0, imem_req}, {31'b0, len != 0});
    endtask

    task automatic wait_done(input int exp_lines);
        int n = 0;
        while (!done && n < 3000) begin
            step();
            n++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("busy_at_done", {31'b0, busy}, 32'd0);
        chk("valid_at_done", {31'b0, instr_valid}, 32'd0);
        chk("accepted", 32'(exp_idx), 32'(exp_len));
        chk("grants", 32'(grant_cnt), 32'(exp_lines));
        chk("issued_count", issued_count, issued_total);
        step();
        chk("done_one_cycle", {31'b0, done}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_1000, 16'd8,  1'b0, 1'b0, 2};
        vecs[1] = '{32'h0000_2000, 16'd6,  1'b0, 1'b0, 2};
        vecs[2] = '{32'h0000_3004, 16'd5,  1'b0, 1'b0, 2};
        vecs[3] = '{32'hFFFF_FFF0, 16'd8,  1'b0, 1'b0, 2};
        vecs[4] = '{32'h0000_4000, 16'd13, 1'b1, 1'b1, 4};
        vecs[5] = '{32'h0000_5000, 16'd1,  1'b0, 1'b1, 1};

        rst_n = 1'b0; start = 1'b0; prog_base = '0; prog_len = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        exp_base = '0; exp_len = 0; exp_idx = 0; grant_cnt = 0;
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_issued", issued_count, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            gnt_rand   = vecs[v].rnd_gnt;
            ready_rand = vecs[v].rnd_ready;
            launch(vecs[v].base, vecs[v].len);
            wait_done(vecs[v].exp_lines);
        end
        gnt_rand = 0; ready_rand = 0;

        // Zero-length program: done at t+1 and no request.
        launch(32'h0000_C000, 16'd0);
        chk("len0_done_t1", {31'b0, done}, 32'd1);
        wait_done(0);

        // Core stalled: credits stop requests at FIFO depth, head word held.
        ready_hold = 1;
        launch(32'h0000_8000, 16'd64);
        repeat (49) step();
        chk("stall_grants", 32'(grant_cnt), 32'd4);
        chk("stall_req_low", {31'b0, imem_req}, 32'd0);
        chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        chk("stall_head", instruction, 32'h0000_8000 + MAGIC);
        ready_hold = 0;
        wait_done(16);

        // Random stalls with a second start while busy, which must be ignored.
        gnt_rand = 1; ready_rand = 1;
        launch(32'h0000_9000, 16'd23);
        repeat (10) step();
        prog_base = 32'hDEAD_0000;
        prog_len  = 16'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_done(6);
        gnt_rand = 0; ready_rand = 0;

        // Reset mid-program, stale responses arrive while idle, then a fresh run.
        launch(32'h0000_A000, 16'd40);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'd0);
        chk("mid_rst_instr", instruction, 32'd0);
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("mid_rst_issued", issued_count, 32'd0);
        issued_total = 0;
        prev_pend = 0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("stale_drained", 32'(rq.size()), 32'd0);
        chk("stale_ignored", {31'b0, instr_valid}, 32'd0);
        launch(32'h0000_B000, 16'd9);
        wait_done(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
